// File: rtl/fp32_pkg.sv
// Shared binary32 field constants and FSM state encodings for the FP32 divider.
package fp32_pkg;

  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int MANT_W    = FRAC_W + 1;
  localparam int EXT_EXP_W = 10;
  localparam int BIAS      = 127;

  localparam logic [EXP_W-1:0]         EXP_MAX = 8'hFF;
  localparam logic [31:0]              QNAN    = 32'h7FC0_0000;
  localparam logic [30:0]              INF     = 31'h7F80_0000;

  // Unbiased exponents need headroom for subnormal normalisation and a/b ratios.
  localparam logic signed [EXT_EXP_W-1:0] E_BIAS = 10'sd127;
  localparam logic signed [EXT_EXP_W-1:0] E_MIN  = -10'sd126;

  typedef enum logic [1:0] {
    A_IDLE,
    A_SEND,
    A_WAIT
  } adapter_state_t;

  typedef enum logic [3:0] {
    C_GET_A,
    C_GET_B,
    C_UNPACK,
    C_SPECIAL,
    C_NORM_A,
    C_NORM_B,
    C_DIV_0,
    C_DIV_1,
    C_NORM_1,
    C_DENORM,
    C_ROUND,
    C_PACK,
    C_PUT_Z
  } core_state_t;

endpackage

// File: rtl/fp32_div_core.sv
// Multi-cycle binary32 divide core with stb/ack handshakes on every operand
// and on the result; restoring division, round to nearest even.
module fp32_div_core
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        input_a_stb,
  input  logic        input_b_stb,
  output logic        input_a_ack,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  core_state_t state, state_next;

  logic [31:0]                  a, b;
  logic [MANT_W-1:0]            a_m, b_m, z_m;
  logic signed [EXT_EXP_W-1:0]  a_e, b_e, z_e;
  logic                         z_s, g, r, s;
  logic [49:0]                  quotient;
  logic [MANT_W-1:0]            remainder;
  logic [5:0]                   count;

  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        special_hit;
  logic [31:0] special_z;

  logic [MANT_W:0]              trial;
  logic                         trial_ge;
  logic [MANT_W-1:0]            trial_sub;
  logic signed [EXT_EXP_W-1:0]  under;
  logic [4:0]                   denorm_sh;
  logic [51:0]                  denorm_v;
  logic [MANT_W:0]              mant_inc;
  logic                         round_up;
  logic signed [EXT_EXP_W-1:0]  exp_biased;
  logic [31:0]                  packed_z;

  assign input_a_ack  = (state == C_GET_A) && input_a_stb;
  assign input_b_ack  = (state == C_GET_B) && input_b_stb;
  assign output_z_stb = (state == C_PUT_Z);

  assign a_nan  = (a[30:23] == EXP_MAX) && (a[22:0] != '0);
  assign b_nan  = (b[30:23] == EXP_MAX) && (b[22:0] != '0);
  assign a_inf  = (a[30:23] == EXP_MAX) && (a[22:0] == '0);
  assign b_inf  = (b[30:23] == EXP_MAX) && (b[22:0] == '0);
  assign a_zero = (a[30:0] == '0);
  assign b_zero = (b[30:0] == '0);

  // Special operands resolved in priority order; NaN results carry no sign.
  always_comb begin
    special_hit = 1'b1;
    special_z   = QNAN;
    if (a_nan || b_nan) begin
      special_z = QNAN;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      special_z = QNAN;
    end else if (a_inf || b_zero) begin
      special_z = {z_s, INF};
    end else if (a_zero || b_inf) begin
      special_z = {z_s, 31'd0};
    end else begin
      special_hit = 1'b0;
    end
  end

  // The remainder never reaches b_m, so the low 24 bits of the difference suffice.
  always_comb begin
    trial     = {remainder, quotient[49]};
    trial_ge  = trial >= {1'b0, b_m};
    trial_sub = trial[MANT_W-1:0] - b_m;
  end

  // Shifts beyond 27 leave nothing but sticky, so the shift is clamped there.
  always_comb begin
    under     = E_MIN - z_e;
    denorm_sh = (under > 10'sd27) ? 5'd27 : under[4:0];
    denorm_v  = {z_m, g, r, 26'd0} >> denorm_sh;
  end

  always_comb begin
    round_up   = g && (r || s || z_m[0]);
    mant_inc   = {1'b0, z_m} + 25'd1;
    exp_biased = z_e + E_BIAS;
    if (exp_biased > 10'sd254) begin
      packed_z = {z_s, INF};
    end else begin
      packed_z = {z_s, (z_m[23] ? exp_biased[7:0] : 8'd0), z_m[22:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= C_GET_A;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      C_GET_A:   if (input_a_stb) state_next = C_GET_B;
      C_GET_B:   if (input_b_stb) state_next = C_UNPACK;
      C_UNPACK:  state_next = C_SPECIAL;
      C_SPECIAL: state_next = special_hit ? C_PUT_Z : C_NORM_A;
      C_NORM_A:  if (a_m[23]) state_next = C_NORM_B;
      C_NORM_B:  if (b_m[23]) state_next = C_DIV_0;
      C_DIV_0:   state_next = C_DIV_1;
      C_DIV_1:   if (count == 6'd49) state_next = C_NORM_1;
      C_NORM_1:  state_next = C_DENORM;
      C_DENORM:  state_next = C_ROUND;
      C_ROUND:   state_next = C_PACK;
      C_PACK:    state_next = C_PUT_Z;
      C_PUT_Z:   if (output_z_ack) state_next = C_GET_A;
      default:   state_next = C_GET_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0; b <= '0; a_m <= '0; b_m <= '0; z_m <= '0;
      a_e <= '0; b_e <= '0; z_e <= '0;
      z_s <= 1'b0; g <= 1'b0; r <= 1'b0; s <= 1'b0;
      quotient <= '0; remainder <= '0; count <= '0; output_z <= '0;
    end else begin
      case (state)
        C_GET_A: if (input_a_stb) a <= input_a;
        C_GET_B: if (input_b_stb) b <= input_b;
        C_UNPACK: begin
          a_m <= {a[30:23] != 8'd0, a[22:0]};
          b_m <= {b[30:23] != 8'd0, b[22:0]};
          a_e <= (a[30:23] == 8'd0) ? E_MIN : $signed({2'b00, a[30:23]}) - E_BIAS;
          b_e <= (b[30:23] == 8'd0) ? E_MIN : $signed({2'b00, b[30:23]}) - E_BIAS;
          z_s <= a[31] ^ b[31];
        end
        C_SPECIAL: if (special_hit) output_z <= special_z;
        C_NORM_A: if (!a_m[23]) begin
          a_m <= a_m << 1;
          a_e <= a_e - 10'sd1;
        end
        C_NORM_B: if (!b_m[23]) begin
          b_m <= b_m << 1;
          b_e <= b_e - 10'sd1;
        end
        C_DIV_0: begin
          quotient  <= {a_m, 26'd0};
          remainder <= '0;
          count     <= '0;
        end
        C_DIV_1: begin
          quotient  <= {quotient[48:0], trial_ge};
          remainder <= trial_ge ? trial_sub : trial[MANT_W-1:0];
          count     <= count + 6'd1;
        end
        // The quotient lies in [2^25, 2^27), so its leading one is bit 26 or 25.
        C_NORM_1: begin
          if (quotient[26]) begin
            z_m <= quotient[26:3];
            g   <= quotient[2];
            r   <= quotient[1];
            s   <= quotient[0] || (remainder != '0);
            z_e <= a_e - b_e;
          end else begin
            z_m <= quotient[25:2];
            g   <= quotient[1];
            r   <= quotient[0];
            s   <= (remainder != '0);
            z_e <= a_e - b_e - 10'sd1;
          end
        end
        C_DENORM: if (z_e < E_MIN) begin
          z_m <= denorm_v[51:28];
          g   <= denorm_v[27];
          r   <= denorm_v[26];
          s   <= s || (denorm_v[25:0] != '0);
          z_e <= E_MIN;
        end
        C_ROUND: if (round_up) begin
          if (mant_inc[24]) begin
            z_m <= 24'h80_0000;
            z_e <= z_e + 10'sd1;
          end else begin
            z_m <= mant_inc[23:0];
          end
        end
        C_PACK: output_z <= packed_z;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fp32_div_unit.sv
// Pulse-in/pulse-out FP32 divider: adapter FSM and result register around
// the handshaking divide core.
module fp32_div_unit
  import fp32_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ready_in,
  output logic [31:0] out,
  output logic        ready_out
);

  adapter_state_t state, state_next;

  logic [31:0] a_reg, b_reg;
  logic        a_sent, b_sent;
  logic        core_rst;
  logic        input_a_stb, input_b_stb, input_a_ack, input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb, output_z_ack;
  logic        start;

  assign core_rst = ~reset_n;

  // A request landing in the ready_out cycle is dropped; the next cycle is the first accepted.
  assign start        = (state == A_IDLE) && ready_in && !ready_out;
  assign input_a_stb  = (state == A_SEND) && !a_sent;
  assign input_b_stb  = (state == A_SEND) && !b_sent;
  assign output_z_ack = (state == A_WAIT) && output_z_stb;

  fp32_div_core u_core (
    .clk          (clock),
    .rst          (core_rst),
    .input_a      (a_reg),
    .input_b      (b_reg),
    .input_a_stb  (input_a_stb),
    .input_b_stb  (input_b_stb),
    .input_a_ack  (input_a_ack),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= A_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      A_IDLE: if (start) state_next = A_SEND;
      A_SEND: if ((a_sent || input_a_ack) && (b_sent || input_b_ack)) state_next = A_WAIT;
      A_WAIT: if (output_z_stb) state_next = A_IDLE;
      default: state_next = A_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      a_sent    <= 1'b0;
      b_sent    <= 1'b0;
      out       <= '0;
      ready_out <= 1'b0;
    end else begin
      if (start) begin
        a_reg  <= a;
        b_reg  <= b;
        a_sent <= 1'b0;
        b_sent <= 1'b0;
      end
      if (input_a_ack) a_sent <= 1'b1;
      if (input_b_ack) b_sent <= 1'b1;
      ready_out <= output_z_ack;
      if (output_z_ack) out <= output_z;
    end
  end

endmodule

// File: tb/tb_fp32_div_unit.sv
// Directed-vector bench for fp32_div_unit: results, latency bounds, pulse
// shape, reset abort and busy-request rejection.
module tb_fp32_div_unit;

  logic        clock;
  logic        reset_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready_in;
  logic [31:0] out;
  logic        ready_out;

  int n_checks;
  int n_fail;

  fp32_div_unit dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .a         (a),
    .b         (b),
    .ready_in  (ready_in),
    .out       (out),
    .ready_out (ready_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] op_a,
                               input logic [31:0] op_b, input logic [31:0] exp_z,
                               input int bound);
    int lat;
    a = op_a;
    b = op_b;
    ready_in = 1'b1;
    @(negedge clock);
    ready_in = 1'b0;
    lat = 0;
    while (!ready_out && lat < 150) begin
      @(negedge clock);
      lat++;
    end
    checkOutput({tag, " ready_out"}, {31'd0, ready_out}, 32'd1);
    checkOutput({tag, " out"}, out, exp_z);
    checkOutput({tag, " latency"}, (lat <= bound) ? 32'd0 : lat, 32'd0);
    @(negedge clock);
    checkOutput({tag, " pulse width"}, {31'd0, ready_out}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulses;
    logic [31:0] got;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    ready_in = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset out", out, 32'h0000_0000);
    checkOutput("reset ready_out", {31'd0, ready_out}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    applyStimulus("1.23/4.56",     32'h3F9D70A4, 32'h4091EB85, 32'h3E8A1AF3, 70);
    applyStimulus("back-to-back",  32'h44F6AF68, 32'h4610099B, 32'h3E5B37F6, 70);
    applyStimulus("neg quotient",  32'h473FF936, 32'hC6DDE29C, 32'hBFDD7D47, 70);
    applyStimulus("1/3",           32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 70);
    applyStimulus("6/3",           32'h40C00000, 32'h40400000, 32'h40000000, 70);
    applyStimulus("x/0",           32'h3F800000, 32'h00000000, 32'h7F800000, 10);
    applyStimulus("0/0",           32'h00000000, 32'h00000000, 32'h7FC00000, 10);
    applyStimulus("-0/1",          32'h80000000, 32'h3F800000, 32'h80000000, 10);
    applyStimulus("nan/1",         32'h7FC00001, 32'h3F800000, 32'h7FC00000, 10);
    applyStimulus("inf/inf",       32'h7F800000, 32'hFF800000, 32'h7FC00000, 10);
    applyStimulus("-inf/1",        32'hFF800000, 32'h3F800000, 32'hFF800000, 10);
    applyStimulus("2/inf",         32'h40000000, 32'h7F800000, 32'h00000000, 10);
    applyStimulus("overflow",      32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 70);
    applyStimulus("underflow sub", 32'h00800000, 32'h40000000, 32'h00400000, 70);
    applyStimulus("subnormal",     32'h00000001, 32'h3F000000, 32'h00000002, 120);
    applyStimulus("tie to zero",   32'h00000001, 32'h40000000, 32'h00000000, 120);
    applyStimulus("tie to even",   32'h00000003, 32'h40000000, 32'h00000002, 120);

    // Reset in the middle of a divide must abort it without a late pulse.
    a = 32'h3F9D70A4;
    b = 32'h4091EB85;
    ready_in = 1'b1;
    @(negedge clock);
    ready_in = 1'b0;
    repeat (20) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("abort out", out, 32'h0000_0000);
    checkOutput("abort ready_out", {31'd0, ready_out}, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    repeat (120) begin
      @(negedge clock);
      if (ready_out) pulses++;
    end
    checkOutput("abort no pulse", pulses, 32'd0);
    applyStimulus("after abort",   32'h473FF936, 32'hC6DDE29C, 32'hBFDD7D47, 70);

    // Requests while busy are dropped, not queued.
    pulses = 0;
    got = '0;
    for (int i = 0; i < 200; i++) begin
      ready_in = (i == 0) || (i == 10) || (i == 30);
      if (i == 0) begin
        a = 32'h3F9D70A4;
        b = 32'h4091EB85;
      end else begin
        a = 32'h40C00000;
        b = 32'h40400000;
      end
      @(negedge clock);
      if (ready_out) begin
        pulses++;
        got = out;
      end
    end
    ready_in = 1'b0;
    checkOutput("busy pulse count", pulses, 32'd1);
    checkOutput("busy out", got, 32'h3E8A1AF3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
